// File: rtl/simd_result_collector.sv
// Collects the four lanes' result/extra_result pairs into a small vector FIFO
// and streams each stored vector out as eight 32-bit words over valid/ready.
module simd_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             res_valid,
  input  logic [31:0]      out_procc0,
  input  logic [31:0]      out_extra_procc0,
  input  logic [31:0]      out_procc1,
  input  logic [31:0]      out_extra_procc1,
  input  logic [31:0]      out_procc2,
  input  logic [31:0]      out_extra_procc2,
  input  logic [31:0]      out_procc3,
  input  logic [31:0]      out_extra_procc3,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_tag,
  output logic             out_last,
  output logic [CNT_W-1:0] fifo_count,
  output logic             busy,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;

  logic [255:0]     mem_q [DEPTH];
  logic [255:0]     hold_q, hold_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       dropCnt_q, dropCnt_d;
  logic             pop, push, drop;
  logic [7:0]       wordBase;
  logic [255:0]     laneVec;

  assign laneVec = {out_procc0, out_extra_procc0, out_procc1, out_extra_procc1,
                    out_procc2, out_extra_procc2, out_procc3, out_extra_procc3};

  // The last handshake of a vector reloads the hold register directly when
  // more data is queued, so consecutive vectors stream without a bubble.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      default: begin
        if (out_ready) begin
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
          end else if (count_q != '0) begin
            pop   = 1'b1;
            idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    push       = res_valid & ((count_q != DEPTH_C) | pop);
    drop       = res_valid & ~push;
    wrPtr_d    = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d    = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    hold_d     = pop ? mem_q[rdPtr_q] : hold_q;
    overflow_d = overflow_q | drop;
    dropCnt_d  = (drop && dropCnt_q != 8'hFF) ? dropCnt_q + 8'd1 : dropCnt_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Vector storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wrPtr_q] <= laneVec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      hold_q     <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= 8'd0;
    end else if (flush) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      hold_q     <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  // Word 0 (lane 0 result) sits in the top bits of the hold register.
  assign wordBase   = {3'd7 - idx_q, 5'd0};
  assign out_valid  = (state_q == SEND);
  assign out_data   = out_valid ? hold_q[wordBase +: 32] : 32'd0;
  assign out_tag    = out_valid ? idx_q : 3'd0;
  assign out_last   = out_valid & (idx_q == 3'd7);
  assign fifo_count = count_q;
  assign busy       = (state_q == SEND) | (count_q != '0);
  assign overflow   = overflow_q;
  assign drop_count = dropCnt_q;

endmodule

// File: tb/tb_simd_result_collector.sv
// Directed bench for simd_result_collector: table-driven vector/backpressure
// cases plus hand-written overflow, push/pop, flush and async reset sequences.
module tb_simd_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        resValid = 1'b0;
  logic [31:0] procc0 = '0, extra0 = '0, procc1 = '0, extra1 = '0;
  logic [31:0] procc2 = '0, extra2 = '0, procc3 = '0, extra3 = '0;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [2:0]  outTag;
  logic        outLast;
  logic [2:0]  fifoCount;
  logic        busy;
  logic        overflow;
  logic [7:0]  dropCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] p0, e0, p1, e1, p2, e2, p3, e3;
    logic [7:0]  readyPat;
    logic [31:0] expWord [8];
  } vec_t;

  vec_t vecs [3];

  simd_result_collector #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .flush(flush), .res_valid(resValid),
    .out_procc0(procc0), .out_extra_procc0(extra0),
    .out_procc1(procc1), .out_extra_procc1(extra1),
    .out_procc2(procc2), .out_extra_procc2(extra2),
    .out_procc3(procc3), .out_extra_procc3(extra3),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .out_tag(outTag), .out_last(outLast), .fifo_count(fifoCount),
    .busy(busy), .overflow(overflow), .drop_count(dropCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Words are numbered in stream order: 0 = procc0, 1 = extra0, ... 7 = extra3.
  function automatic logic [31:0] laneWord(input int v, input int w);
    return {4'hA, 4'(v), 4'(w), 20'h5A5A5};
  endfunction

  // Called at a negedge; pulses res_valid for one cycle and returns at the next negedge.
  task automatic applyStimulus(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
    procc0 = w0; extra0 = w1; procc1 = w2; extra1 = w3;
    procc2 = w4; extra2 = w5; procc3 = w6; extra3 = w7;
    resValid = 1'b1;
    @(negedge clk);
    resValid = 1'b0;
  endtask

  task automatic pushPattern(input int v);
    applyStimulus(laneWord(v, 0), laneWord(v, 1), laneWord(v, 2), laneWord(v, 3),
                  laneWord(v, 4), laneWord(v, 5), laneWord(v, 6), laneWord(v, 7));
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic checkWord(input string name, input logic [31:0] exp, input int w);
    checkOutput({name, "_valid"}, 32'(outValid), 32'd1);
    checkOutput({name, "_data"}, outData, exp);
    checkOutput({name, "_tag"}, 32'(outTag), 32'(w));
    checkOutput({name, "_last"}, 32'(outLast), 32'(w == 7));
  endtask

  initial begin
    vecs[0].p0 = 32'hDEAD0000; vecs[0].e0 = 32'hDEAD0001; vecs[0].p1 = 32'hDEAD0002; vecs[0].e1 = 32'hDEAD0003;
    vecs[0].p2 = 32'hDEAD0004; vecs[0].e2 = 32'hDEAD0005; vecs[0].p3 = 32'hDEAD0006; vecs[0].e3 = 32'hDEAD0007;
    vecs[0].readyPat = 8'b1001_1001;
    vecs[0].expWord = '{32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003,
                        32'hDEAD0004, 32'hDEAD0005, 32'hDEAD0006, 32'hDEAD0007};
    vecs[1].p0 = 32'h00000001; vecs[1].e0 = 32'hFFFFFFFF; vecs[1].p1 = 32'h80000000; vecs[1].e1 = 32'h7FFFFFFF;
    vecs[1].p2 = 32'h12345678; vecs[1].e2 = 32'h9ABCDEF0; vecs[1].p3 = 32'h0F0F0F0F; vecs[1].e3 = 32'hF0F0F0F0;
    vecs[1].readyPat = 8'b0101_0101;
    vecs[1].expWord = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                        32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0};
    vecs[2].p0 = 32'hCAFE0010; vecs[2].e0 = 32'hCAFE0011; vecs[2].p1 = 32'hCAFE0020; vecs[2].e1 = 32'hCAFE0021;
    vecs[2].p2 = 32'hCAFE0030; vecs[2].e2 = 32'hCAFE0031; vecs[2].p3 = 32'hCAFE0040; vecs[2].e3 = 32'hCAFE0041;
    vecs[2].readyPat = 8'b1100_0011;
    vecs[2].expWord = '{32'hCAFE0010, 32'hCAFE0011, 32'hCAFE0020, 32'hCAFE0021,
                        32'hCAFE0030, 32'hCAFE0031, 32'hCAFE0040, 32'hCAFE0041};

    // Reset state, then idle for 20 cycles with no stimulus
    #2;
    checkOutput("rst_data", outData, 32'd0);
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_tag", 32'(outTag), 32'd0);
    checkOutput("rst_last", 32'(outLast), 32'd0);
    checkOutput("rst_count", 32'(fifoCount), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drops", 32'(dropCount), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_valid", 32'(outValid), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
    end

    // Single vector, ready held high: word 0 two cycles after the pulse, no gaps
    outReady = 1'b1;
    applyStimulus(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                  32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    checkOutput("lat_valid_n1", 32'(outValid), 32'd0);
    checkOutput("lat_count_n1", 32'(fifoCount), 32'd1);
    checkOutput("lat_busy_n1", 32'(busy), 32'd1);
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      checkWord("single", {8{4'(w + 1)}}, w);
    end
    @(negedge clk);
    checkOutput("single_idle_valid", 32'(outValid), 32'd0);
    checkOutput("single_idle_busy", 32'(busy), 32'd0);

    // Table-driven vectors under different backpressure patterns
    for (int t = 0; t < 3; t++) begin
      int k;
      int cyc;
      logic rdy;
      outReady = 1'b0;
      applyStimulus(vecs[t].p0, vecs[t].e0, vecs[t].p1, vecs[t].e1,
                    vecs[t].p2, vecs[t].e2, vecs[t].p3, vecs[t].e3);
      k = 0;
      cyc = 0;
      while (k < 8 && cyc < 100) begin
        if (outValid) begin
          checkOutput("tbl_data", outData, vecs[t].expWord[k]);
          checkOutput("tbl_tag", 32'(outTag), 32'(k));
          checkOutput("tbl_last", 32'(outLast), 32'(k == 7));
          rdy = vecs[t].readyPat[cyc % 8];
          outReady = rdy;
          if (rdy) k++;
        end else begin
          outReady = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
      checkOutput("tbl_words_done", 32'(k), 32'd8);
      outReady = 1'b0;
      checkOutput("tbl_end_valid", 32'(outValid), 32'd0);
      checkOutput("tbl_end_busy", 32'(busy), 32'd0);
    end

    // Overflow: six vectors with the consumer stalled, one is dropped
    outReady = 1'b0;
    for (int v = 0; v < 6; v++) pushPattern(v);
    checkOutput("ovf_count", 32'(fifoCount), 32'd4);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_drops", 32'(dropCount), 32'd1);
    checkOutput("ovf_busy", 32'(busy), 32'd1);
    outReady = 1'b1;
    for (int n = 0; n < 40; n++) begin
      checkWord("ovf_stream", laneWord(n / 8, n % 8), n % 8);
      @(negedge clk);
    end
    checkOutput("ovf_end_valid", 32'(outValid), 32'd0);
    checkOutput("ovf_end_count", 32'(fifoCount), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Flush mid-stream at word 3 with two vectors queued
    outReady = 1'b0;
    for (int v = 0; v < 3; v++) pushPattern(v);
    outReady = 1'b1;
    repeat (3) @(negedge clk);
    outReady = 1'b0;
    checkOutput("fl_pre_tag", 32'(outTag), 32'd3);
    checkOutput("fl_pre_count", 32'(fifoCount), 32'd2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("fl_valid", 32'(outValid), 32'd0);
    checkOutput("fl_count", 32'(fifoCount), 32'd0);
    checkOutput("fl_overflow", 32'(overflow), 32'd0);
    checkOutput("fl_drops", 32'(dropCount), 32'd0);
    checkOutput("fl_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("fl_stays_idle", 32'(outValid), 32'd0);

    // Simultaneous push and pop on the final handshake of a full FIFO
    for (int v = 0; v < 5; v++) pushPattern(v);
    checkOutput("pp_count_full", 32'(fifoCount), 32'd4);
    outReady = 1'b1;
    begin
      int guard = 0;
      while (!(outValid && outTag == 3'd7) && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      checkOutput("pp_reached_last", 32'(outTag), 32'd7);
    end
    applyStimulus(laneWord(5, 0), laneWord(5, 1), laneWord(5, 2), laneWord(5, 3),
                  laneWord(5, 4), laneWord(5, 5), laneWord(5, 6), laneWord(5, 7));
    checkOutput("pp_count", 32'(fifoCount), 32'd4);
    checkOutput("pp_overflow", 32'(overflow), 32'd0);
    checkOutput("pp_drops", 32'(dropCount), 32'd0);
    checkWord("pp_next", laneWord(1, 0), 0);

    // Asynchronous reset between clock edges
    outReady = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(outValid), 32'd0);
    checkOutput("ar_data", outData, 32'd0);
    checkOutput("ar_count", 32'(fifoCount), 32'd0);
    checkOutput("ar_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ar_after_valid", 32'(outValid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_result_collector.md
Name: simd_result_collector

Overview:
- Downstream stage of the 4-lane SIMD core; sits directly after the four ALU processors.
- On each `res_valid` pulse (driven from the combined all-processors-done condition), captures all eight 32-bit lane outputs (result plus extra_result per lane) as one 256-bit vector into a small FIFO.
- Serializes each stored vector as eight 32-bit words over a valid/ready stream to the consumer.

Parameters:
- DEPTH, 4, number of 256-bit vectors the FIFO holds; power of two, ≥2.
- CNT_W, 3, width of fifo_count; must hold 0..DEPTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO, serializer and status.
- res_valid  in  1  one-cycle capture strobe for the lane outputs.
- out_procc0, out_extra_procc0, out_procc1, out_extra_procc1  in  32 each  lane 0/1 result and extra_result.
- out_procc2, out_extra_procc2, out_procc3, out_extra_procc3  in  32 each  lane 2/3 result and extra_result.
- out_data  out  32  current serialized word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_tag  out  3  word index: {lane[1:0], is_extra}.
- out_last  out  1  high on word 7 (tag 3'b111).
- fifo_count  out  CNT_W  vectors stored, excluding the one being serialized.
- busy  out  1  serializer in SEND or FIFO non-empty.
- overflow  out  1  sticky flag: a vector was dropped.
- drop_count  out  8  dropped vectors; saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0.
  - FIFO pointers and fifo_count are 0.
  - State is IDLE.
- flush=1 has the same effect as reset, applied synchronously at the edge; it has priority over all other inputs in that cycle.
- Push rule:
  - On res_valid=1, the vector {procc0, extra0, procc1, extra1, procc2, extra2, procc3, extra3} is written at the write pointer.
  - A push is accepted if fifo_count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the vector is dropped: overflow is set to 1 and drop_count increments, saturating at 255.
- Pointers: write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. fifo_count changes by +1 on push only, −1 on pop only, and 0 on simultaneous push and pop.
- State machine:
  - IDLE:
    - out_valid=0.
    - If fifo_count>0: pop into the 256-bit hold register, set idx=0, go to SEND.
  - SEND:
    - out_valid=1; out_data=hold word idx; out_tag=idx; out_last=(idx==7).
    - On out_valid & out_ready with idx<7: idx increments.
    - On out_valid & out_ready with idx==7: if fifo_count>0, pop and reload hold, idx=0, stay in SEND (back-to-back, no bubble); else go to IDLE.
- Word order: idx 0 = out_procc0, 1 = out_extra_procc0, 2 = out_procc1, … 7 = out_extra_procc3.
- Stream stability: while out_valid=1 and out_ready=0, out_data, out_tag and out_last hold stable.
- Latency: a res_valid at cycle N into an empty, idle block produces out_valid=1 with word 0 at cycle N+2.
- A push in the same cycle as a pop from IDLE is written normally; fifo_count stays unchanged.
- busy = (state==SEND) | (fifo_count!=0).
- All outputs are registered except out_data, out_tag and out_last, which are muxed from registered hold/idx.

Test Plan:
- Reset/idle: reset=0 then 1, no stimulus -> all outputs 0, busy=0 for 20 cycles.
- Single vector: lanes carry 0x11111111..0x88888888 in port order, res_valid pulse at cycle 10, out_ready=1 -> out_valid rises at cycle 12; 8 words in order with tags 0..7; out_last only on 0x88888888; IDLE at cycle 20.
- Backpressure: same vector, out_ready toggling 1,0,0,1,… -> no word lost or duplicated; out_data/out_tag stable while stalled.
- Overflow: out_ready=0, 6 res_valid pulses with DEPTH=4 -> 1 vector in hold, fifo_count=4, overflow=1, drop_count=1. Then out_ready=1 -> 5 vectors (40 words) emitted back-to-back with no bubble between out_last and the next word 0.
- Simultaneous push/pop: fifo_count=4, res_valid coincides with the handshake on word 7 -> push accepted, fifo_count stays 4, overflow stays 0.
- Flush/reset mid-operation: flush=1 at SEND idx=3 with fifo_count=2 -> next cycle out_valid=0, fifo_count=0, overflow=0. Repeat with async reset mid-cycle -> outputs 0 immediately, before the clock edge.
